// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and RAM-side signals of the load/store controller.
// The slave modport is the controller; the master modport is the core plus RAM.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [17:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic [3:0]  mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Byte/half/word load-store controller in front of a word-only RAM. Accesses that
// cross a word boundary are split into two RAM transactions.
module lsu_mem_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  lsu_mem_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StIssue0, StIssue1, StData, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [17:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word0_q;

  logic        rsp_valid_q, rsp_err_q, mem_read_q;
  logic [31:0] rsp_rdata_q, mem_wdata_q;
  logic [15:0] mem_addr_q;
  logic [3:0]  mem_write_q;

  logic        idle, c_we, c_err, split;
  logic [2:0]  c_f3;
  logic [17:0] c_addr;
  logic [31:0] c_wdata;
  logic [1:0]  c_off;
  logic [3:0]  smask;
  logic [7:0]  mask8;
  logic [63:0] wide, raw64;
  logic [31:0] raw, ext;

  assign idle = (state_q == StIdle);

  // In IDLE the live request drives the datapath so ISSUE0 outputs can be registered
  // at the accept edge; afterwards the latched copy is used.
  always_comb begin
    c_we    = idle ? bus.req_we     : we_q;
    c_f3    = idle ? bus.req_funct3 : f3_q;
    c_addr  = idle ? bus.req_addr   : addr_q;
    c_wdata = idle ? bus.req_wdata  : wdata_q;
    c_off   = c_addr[1:0];

    smask = 4'b0000;
    unique case (c_f3[1:0])
      2'b00:   smask = 4'b0001;
      2'b01:   smask = 4'b0011;
      2'b10:   smask = 4'b1111;
      default: smask = 4'b0000;
    endcase
    mask8 = {4'b0000, smask} << c_off;
    split = |mask8[7:4];
    wide  = {32'b0, c_wdata} << {c_off, 3'b000};

    if (c_we) c_err = c_f3[2] || (c_f3[1:0] == 2'b11);
    else      c_err = (c_f3[1:0] == 2'b11) || (c_f3[2] && c_f3[1]);

    // Split loads keep word0 from ISSUE1; the word in mem_rdata now is the last one issued.
    raw64 = split ? {bus.mem_rdata, word0_q} : {32'b0, bus.mem_rdata};
    raw   = raw64[31:0];
    raw   = 32'(raw64 >> {c_off, 3'b000});

    ext = raw;
    case (c_f3)
      3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
      3'b100:  ext = {24'b0, raw[7:0]};
      3'b101:  ext = {16'b0, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.req_valid) state_d = c_err ? StResp : StIssue0;
      StIssue0: state_d = split ? StIssue1 : (c_we ? StResp : StData);
      StIssue1: state_d = c_we ? StResp : StData;
      StData:   state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      f3_q        <= 3'b0;
      addr_q      <= 18'b0;
      wdata_q     <= 32'b0;
      word0_q     <= 32'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'b0;
      mem_addr_q  <= 16'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 4'b0;
      mem_wdata_q <= 32'b0;
    end else begin
      state_q <= state_d;
      if (idle && bus.req_valid) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state_q == StIssue1) word0_q <= bus.mem_rdata;

      mem_read_q  <= 1'b0;
      mem_write_q <= 4'b0;
      if (state_d == StIssue0) begin
        mem_addr_q <= c_addr[17:2];
        if (c_we) begin
          mem_write_q <= mask8[3:0];
          mem_wdata_q <= wide[31:0];
        end else begin
          mem_read_q <= 1'b1;
        end
      end else if (state_d == StIssue1) begin
        mem_addr_q <= c_addr[17:2] + 16'd1;
        if (c_we) begin
          mem_write_q <= mask8[7:4];
          mem_wdata_q <= wide[63:32];
        end else begin
          mem_read_q <= 1'b1;
        end
      end

      rsp_valid_q <= (state_d == StResp);
      rsp_err_q   <= (state_d == StResp) && c_err;
      rsp_rdata_q <= (state_q == StData) ? ext : 32'b0;
    end
  end

  assign bus.req_ready = idle;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a word RAM model and an expected-response queue.
module tb_lsu_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if bus ();
  lsu_mem_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Synchronous word RAM with byte lanes and a backdoor write port for preloading.
  logic [31:0] mem [0:65535];
  logic [31:0] rd_q = 32'b0;
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = 16'b0;
  logic [31:0] bd_data = 32'b0;
  assign bus.mem_rdata = rd_q;
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (bus.mem_read) rd_q <= mem[bus.mem_addr];
    for (int i = 0; i < 4; i++)
      if (bus.mem_write[i]) mem[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  logic        tr_read  [0:9];
  logic [3:0]  tr_write [0:9];
  logic [15:0] tr_addr  [0:9];
  logic [31:0] tr_wdata [0:9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [17:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    exp_t e;
    int   lat;
    int   guard;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb.push_back(e);
    for (int i = 0; i < 10; i++) begin
      tr_read[i]  = 1'b0;
      tr_write[i] = 4'b0;
      tr_addr[i]  = 16'b0;
      tr_wdata[i] = 32'b0;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, " accept"}, {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c < 10; c++) begin
      tr_read[c]  = bus.mem_read;
      tr_write[c] = bus.mem_write;
      tr_addr[c]  = bus.mem_addr;
      tr_wdata[c] = bus.mem_wdata;
      if (bus.rsp_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    chk({tag, " latency"}, 32'(lat), 32'(e.lat));
    chk({tag, " rdata"}, bus.rsp_rdata, e.rdata);
    chk({tag, " err"}, {31'b0, bus.rsp_err}, {31'b0, e.err});
    @(negedge clk);
    chk({tag, " pulse/ready"}, {30'b0, bus.rsp_valid, bus.req_ready}, 32'd1);
  endtask

  initial begin
    int pulses;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b0;
    bus.req_addr   = 18'b0;
    bus.req_wdata  = 32'b0;

    // Reset with RAM preload through the backdoor.
    @(negedge clk);
    bd_we = 1'b1; bd_addr = 16'd0; bd_data = 32'h44332211;
    @(negedge clk);
    bd_addr = 16'd1; bd_data = 32'h88776655;
    @(negedge clk);
    bd_we = 1'b0;
    chk("reset ready", {31'b0, bus.req_ready}, 32'd1);
    chk("reset strobes", {25'b0, bus.mem_read, bus.mem_write, bus.rsp_valid, bus.rsp_err}, 32'd0);
    chk("reset mem_addr", {16'b0, bus.mem_addr}, 32'd0);
    chk("reset mem_wdata", bus.mem_wdata, 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_req("lw0", 1'b0, 3'b010, 18'd0, 32'd0, 32'h44332211, 1'b0, 3);
    chk("lw0 read c1", {31'b0, tr_read[1]}, 32'd1);
    chk("lw0 read c2", {31'b0, tr_read[2]}, 32'd0);
    chk("lw0 addr c1", {16'b0, tr_addr[1]}, 32'd0);

    run_req("lb3",  1'b0, 3'b000, 18'd3, 32'd0, 32'h00000044, 1'b0, 3);
    run_req("lb7",  1'b0, 3'b000, 18'd7, 32'd0, 32'hFFFFFF88, 1'b0, 3);
    run_req("lbu7", 1'b0, 3'b100, 18'd7, 32'd0, 32'h00000088, 1'b0, 3);
    run_req("lhu6", 1'b0, 3'b101, 18'd6, 32'd0, 32'h00008877, 1'b0, 3);
    run_req("lh6",  1'b0, 3'b001, 18'd6, 32'd0, 32'hFFFF8877, 1'b0, 3);

    run_req("lw2 split", 1'b0, 3'b010, 18'd2, 32'd0, 32'h66554433, 1'b0, 4);
    chk("lw2 read c1", {31'b0, tr_read[1]}, 32'd1);
    chk("lw2 read c2", {31'b0, tr_read[2]}, 32'd1);
    chk("lw2 read c3", {31'b0, tr_read[3]}, 32'd0);
    chk("lw2 addr c1", {16'b0, tr_addr[1]}, 32'd0);
    chk("lw2 addr c2", {16'b0, tr_addr[2]}, 32'd1);

    run_req("sh3 split", 1'b1, 3'b001, 18'd3, 32'h0000BEEF, 32'd0, 1'b0, 3);
    chk("sh3 mask c1", {28'b0, tr_write[1]}, 32'h8);
    chk("sh3 wdata c1", tr_wdata[1], 32'hEF000000);
    chk("sh3 mask c2", {28'b0, tr_write[2]}, 32'h1);
    chk("sh3 wdata c2", tr_wdata[2], 32'h000000BE);
    run_req("lw0 after sh", 1'b0, 3'b010, 18'd0, 32'd0, 32'hEF332211, 1'b0, 3);
    run_req("lw4 after sh", 1'b0, 3'b010, 18'd4, 32'd0, 32'h887766BE, 1'b0, 3);

    run_req("sw wrap", 1'b1, 3'b010, 18'h3FFFE, 32'hA1B2C3D4, 32'd0, 1'b0, 3);
    chk("sw wrap addr c1", {16'b0, tr_addr[1]}, 32'h0000FFFF);
    chk("sw wrap mask c1", {28'b0, tr_write[1]}, 32'hC);
    chk("sw wrap wdata c1", tr_wdata[1], 32'hC3D40000);
    chk("sw wrap addr c2", {16'b0, tr_addr[2]}, 32'h00000000);
    chk("sw wrap mask c2", {28'b0, tr_write[2]}, 32'h3);
    chk("sw wrap wdata c2", tr_wdata[2], 32'h0000A1B2);
    run_req("lw0 after wrap", 1'b0, 3'b010, 18'd0, 32'd0, 32'hEF33A1B2, 1'b0, 3);

    run_req("load f3 011", 1'b0, 3'b011, 18'd0, 32'd0, 32'd0, 1'b1, 1);
    chk("err load strobes", {27'b0, tr_read[1], tr_write[1]}, 32'd0);
    run_req("store f3 100", 1'b1, 3'b100, 18'd4, 32'hFFFFFFFF, 32'd0, 1'b1, 1);
    chk("err store strobes", {27'b0, tr_read[1], tr_write[1]}, 32'd0);

    run_req("sb5", 1'b1, 3'b000, 18'd5, 32'h000000AA, 32'd0, 1'b0, 2);
    chk("sb5 mask c1", {28'b0, tr_write[1]}, 32'h2);
    chk("sb5 wdata c1", tr_wdata[1], 32'h0000AA00);
    run_req("lhu5", 1'b0, 3'b101, 18'd5, 32'd0, 32'h000077AA, 1'b0, 3);

    // Abort a split store with reset during its second RAM cycle.
    pulses = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 18'd1;
    bus.req_wdata  = 32'h11223344;
    chk("abort accept", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort mask c1", {28'b0, bus.mem_write}, 32'hE);
    @(negedge clk);
    rst_n = 1'b0;
    pulses += int'(bus.rsp_valid);
    @(negedge clk);
    chk("abort mask after rst", {28'b0, bus.mem_write}, 32'd0);
    pulses += int'(bus.rsp_valid);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort ready after rst", {31'b0, bus.req_ready}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      pulses += int'(bus.rsp_valid);
      @(negedge clk);
    end
    chk("abort no rsp", 32'(pulses), 32'd0);
    chk("abort word0 ram", mem[0], 32'h223344B2);
    run_req("lw0 after abort", 1'b0, 3'b010, 18'd0, 32'd0, 32'h223344B2, 1'b0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
